// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: board/control-side signals of the instruction phase sequencer.
interface phase_sequencer_if #(
   parameter int NUM_PHASES = 5,
   parameter int IW         = 16,
   parameter int CNT_W      = 16
);
   localparam int PHASE_W = $clog2(NUM_PHASES + 1);
   logic                  exec;
   logic                  step;
   logic                  halt_req;
   logic [IW-1:0]         instr_in;
   logic [IW-1:0]         instr_out;
   logic [PHASE_W-1:0]    phase;
   logic [NUM_PHASES-1:0] phase_oh;
   logic                  executing;
   logic                  pc_e;
   logic                  halted;
   logic [CNT_W-1:0]      instr_count;
   modport master (
      output exec, step, halt_req, instr_in,
      input  instr_out, phase, phase_oh, executing, pc_e, halted, instr_count
   );
   modport slave (
      input  exec, step, halt_req, instr_in,
      output instr_out, phase, phase_oh, executing, pc_e, halted, instr_count
   );
endinterface

// File: rtl/phase_sequencer.sv
// phase_sequencer: instruction phase counter with run/stop, single-step and halt control.
module phase_sequencer #(
   parameter int NUM_PHASES = 5,
   parameter int IW         = 16,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   phase_sequencer_if.slave  bus
);
   localparam int PHASE_W = $clog2(NUM_PHASES + 1);
   localparam logic [PHASE_W-1:0] LAST = PHASE_W'(NUM_PHASES);
   logic [PHASE_W-1:0] phase_q;
   logic [IW-1:0]      instr_q;
   logic [CNT_W-1:0]   count_q;
   logic               pc_e_q, halted_q, stop_pending, step_mode, exec_d, step_d;
   logic               exec_p, step_p, busy;
   assign exec_p = bus.exec & ~exec_d;
   assign step_p = bus.step & ~step_d;
   assign busy   = phase_q != '0;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         phase_q      <= '0;
         instr_q      <= '0;
         count_q      <= '0;
         pc_e_q       <= 1'b0;
         halted_q     <= 1'b0;
         stop_pending <= 1'b0;
         step_mode    <= 1'b0;
         exec_d       <= 1'b0;
         step_d       <= 1'b0;
      end else begin
         exec_d <= bus.exec;
         step_d <= bus.step;
         pc_e_q <= 1'b0;
         if (!busy) begin
            if (exec_p || step_p) begin
               phase_q   <= PHASE_W'(1);
               step_mode <= ~exec_p;
               instr_q   <= bus.instr_in;
               halted_q  <= 1'b0;
            end
         end else if (phase_q != LAST) begin
            phase_q <= phase_q + 1'b1;
            if (exec_p) stop_pending <= 1'b1;
         end else begin
            count_q <= count_q + 1'b1;
            pc_e_q  <= 1'b1;
            // An exec pulse in the final phase stops at this same boundary.
            if (bus.halt_req || stop_pending || step_mode || exec_p) begin
               phase_q      <= '0;
               stop_pending <= 1'b0;
               step_mode    <= 1'b0;
               halted_q     <= halted_q | bus.halt_req;
            end else begin
               phase_q <= PHASE_W'(1);
               instr_q <= bus.instr_in;
            end
         end
      end
   assign bus.phase       = phase_q;
   assign bus.executing   = busy;
   assign bus.phase_oh    = busy ? {{(NUM_PHASES-1){1'b0}}, 1'b1} << (phase_q - 1'b1) : '0;
   assign bus.instr_out   = instr_q;
   assign bus.instr_count = count_q;
   assign bus.pc_e        = pc_e_q;
   assign bus.halted      = halted_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: table-driven scoreboard bench for the 5-phase sequencer plus a 3-phase wrap instance.
module tb_phase_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   always #5 clk = ~clk;
   phase_sequencer_if #(.NUM_PHASES(5), .IW(16), .CNT_W(16)) b5 ();
   phase_sequencer_if #(.NUM_PHASES(3), .IW(16), .CNT_W(4))  b3 ();
   phase_sequencer #(.NUM_PHASES(5), .IW(16), .CNT_W(16)) dut5 (.clk(clk), .rst(rst), .bus(b5.slave));
   phase_sequencer #(.NUM_PHASES(3), .IW(16), .CNT_W(4))  dut3 (.clk(clk), .rst(rst), .bus(b3.slave));
   typedef struct {
      logic        ex, st, hr;
      logic [15:0] ins;
      logic [2:0]  ph;
      logic        pce, hl;
      logic [15:0] io;
      logic [15:0] cnt;
   } vec_t;
   vec_t tbl[$];
   vec_t sb[$];
   localparam logic [15:0] A = 16'hA5A5, B = 16'h1234, C = 16'h5555, D = 16'h0F0F;
   localparam logic [15:0] E = 16'h1111, F = 16'h2222, G = 16'h3333, H = 16'h4444;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask
   task automatic v(input logic ex, st, hr, input logic [15:0] ins, input logic [2:0] ph,
                    input logic pce, hl, input logic [15:0] io, input logic [15:0] cnt);
      vec_t r;
      r = '{ex, st, hr, ins, ph, pce, hl, io, cnt};
      tbl.push_back(r);
   endtask
   initial begin
      vec_t e;
      logic [4:0] oh;
      {b5.exec, b5.step, b5.halt_req, b5.instr_in} = '0;
      {b3.exec, b3.step, b3.halt_req, b3.instr_in} = '0;
      // run
      v(1,0,0,A, 1,0,0,A,0); v(1,0,0,B, 2,0,0,A,0); v(1,0,0,B, 3,0,0,A,0); v(1,0,0,B, 4,0,0,A,0);
      v(1,0,0,B, 5,0,0,A,0); v(1,0,0,B, 1,1,0,B,1); v(1,0,0,C, 2,0,0,B,1); v(1,0,0,C, 3,0,0,B,1);
      v(1,0,0,C, 4,0,0,B,1); v(1,0,0,C, 5,0,0,B,1); v(0,0,0,C, 1,1,0,C,2); v(0,0,0,C, 2,0,0,C,2);
      // stop requested in phase 2, then in phase 5
      v(1,0,0,C, 3,0,0,C,2); v(0,0,0,C, 4,0,0,C,2); v(0,0,0,C, 5,0,0,C,2); v(0,0,0,C, 0,1,0,C,3);
      v(0,0,0,C, 0,0,0,C,3); v(1,0,0,D, 1,0,0,D,3); v(0,0,0,D, 2,0,0,D,3); v(0,0,0,D, 3,0,0,D,3);
      v(0,0,0,D, 4,0,0,D,3); v(0,0,0,D, 5,0,0,D,3); v(1,0,0,D, 0,1,0,D,4); v(0,0,0,D, 0,0,0,D,4);
      // single step, step ignored mid-instruction, step+exec free runs
      v(0,1,0,E, 1,0,0,E,4); v(0,0,0,E, 2,0,0,E,4); v(0,1,0,E, 3,0,0,E,4); v(0,0,0,E, 4,0,0,E,4);
      v(0,0,0,E, 5,0,0,E,4); v(0,0,0,E, 0,1,0,E,5); v(0,0,0,E, 0,0,0,E,5); v(1,1,0,F, 1,0,0,F,5);
      v(0,0,0,F, 2,0,0,F,5); v(0,0,0,F, 3,0,0,F,5); v(0,0,0,F, 4,0,0,F,5); v(0,0,0,F, 5,0,0,F,5);
      // halt ignored in phase 3, taken in phase 5, cleared by next start
      v(0,0,0,G, 1,1,0,G,6); v(0,0,0,G, 2,0,0,G,6); v(0,0,0,G, 3,0,0,G,6); v(0,0,1,G, 4,0,0,G,6);
      v(0,0,0,G, 5,0,0,G,6); v(0,0,1,G, 0,1,1,G,7); v(0,0,0,G, 0,0,1,G,7); v(1,0,0,H, 1,0,0,H,7);
      v(1,0,0,H, 2,0,0,H,7); v(0,0,0,H, 3,0,0,H,7); v(1,0,0,H, 4,0,0,H,7); v(0,0,0,H, 5,0,0,H,7);
      v(0,0,0,H, 0,1,0,H,8);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      // asynchronous reset in the middle of phase 3
      @(negedge clk); b5.exec = 1'b1; b5.instr_in = 16'hBEEF;
      @(negedge clk); b5.exec = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("pre_reset_phase", 32'(b5.phase), 3);
      chk("pre_reset_iout", 32'(b5.instr_out), 32'hBEEF);
      #1 rst = 1'b0; #1;
      chk("reset_phase", 32'(b5.phase), 0);
      chk("reset_exec", 32'(b5.executing), 0);
      chk("reset_oh", 32'(b5.phase_oh), 0);
      chk("reset_iout", 32'(b5.instr_out), 0);
      chk("reset_pce", 32'(b5.pc_e), 0);
      chk("reset_halted", 32'(b5.halted), 0);
      chk("reset_cnt", 32'(b5.instr_count), 0);
      @(negedge clk); rst = 1'b1; b5.instr_in = '0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk($sformatf("idle%0d_phase", i), 32'(b5.phase), 0);
      end
      foreach (tbl[i]) begin
         @(negedge clk);
         b5.exec = tbl[i].ex; b5.step = tbl[i].st; b5.halt_req = tbl[i].hr; b5.instr_in = tbl[i].ins;
         sb.push_back(tbl[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         oh = e.ph == 0 ? 5'b0 : 5'b1 << (e.ph - 3'd1);
         chk($sformatf("row%0d_phase", i), 32'(b5.phase), 32'(e.ph));
         chk($sformatf("row%0d_oh", i), 32'(b5.phase_oh), 32'(oh));
         chk($sformatf("row%0d_executing", i), 32'(b5.executing), 32'(e.ph != 0));
         chk($sformatf("row%0d_pc_e", i), 32'(b5.pc_e), 32'(e.pce));
         chk($sformatf("row%0d_halted", i), 32'(b5.halted), 32'(e.hl));
         chk($sformatf("row%0d_iout", i), 32'(b5.instr_out), 32'(e.io));
         chk($sformatf("row%0d_cnt", i), 32'(b5.instr_count), 32'(e.cnt));
      end
      chk("sb_empty", 32'(sb.size()), 0);
      // 3-phase instance: free run 17 instructions, counter wraps to 1
      @(negedge clk); b3.exec = 1'b1;
      for (int k = 0; k <= 51; k++) begin
         @(posedge clk); #1;
         if (k < 3) chk($sformatf("p3_oh%0d", k), 32'(b3.phase_oh), 32'(1 << k));
      end
      chk("p3_wrap_cnt", 32'(b3.instr_count), 1);
      chk("p3_wrap_pce", 32'(b3.pc_e), 1);
      chk("p3_wrap_phase", 32'(b3.phase), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Parametrised instruction-phase sequencer and run/stop controller for the 16-bit teaching processor. It generates the per-instruction phase count (idle phase 0, then execution phases 1..NUM_PHASES) and latches the instruction word at each instruction boundary. It pulses the PC advance enable and handles start/stop, single-step and halt requests. It sits between the board inputs (exec/step buttons, instruction source) and the control/datapath, replacing the hard-coded 5-phase counter.

Parameters:
NUM_PHASES, 5, execution phases per instruction (>=2)
IW, 16, instruction word width
CNT_W, 16, retired-instruction counter width
PHASE_W (localparam), clog2(NUM_PHASES+1), width of binary phase number

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
exec  in  1  run/stop button level, synchronous to clk, edge-detected internally
step  in  1  single-step button level, synchronous, edge-detected internally
halt_req  in  1  halt decoded by control, sampled only in phase NUM_PHASES
instr_in  in  IW  next instruction word from instruction source
instr_out  out  IW  latched instruction for current execution
phase  out  PHASE_W  binary phase, 0 = idle
phase_oh  out  NUM_PHASES  one-hot phase, bit k-1 high in phase k, all-zero when idle
executing  out  1  high while phase != 0
pc_e  out  1  one-cycle PC advance pulse
halted  out  1  sticky: stopped by halt_req
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=0, asynchronous): phase=0, executing=0, pc_e=0, halted=0, instr_count=0, instr_out=0. All internal flags (stop_pending, step_mode, exec_d, step_d) = 0. Reset is effective mid-instruction with no completion side effects.
- Edge detect: exec_p = exec & ~exec_d; step_p = step & ~step_d. exec_d and step_d are registered every cycle. Holding a button produces exactly one pulse.
- IDLE (phase 0):
  - exec_p -> phase 1, step_mode=0, instr_out<=instr_in, halted<=0.
  - Otherwise step_p -> phase 1, step_mode=1, instr_out<=instr_in, halted<=0.
  - exec_p has priority over step_p when both occur in the same cycle.
  - No pulse -> remain idle.
- RUN, phase k with 1<=k<NUM_PHASES: phase<=k+1 unconditionally.
- Any exec_p while executing sets stop_pending, including in phase NUM_PHASES. step_p while executing is ignored.
- Phase NUM_PHASES (instruction completes):
  - Every cycle: instr_count<=instr_count+1 and pc_e<=1, so pc_e is high during the following cycle only.
  - If halt_req: phase<=0, halted<=1.
  - Else if stop_pending or step_mode, or exec_p in this same cycle: phase<=0.
  - Else phase<=1 and instr_out<=instr_in (back-to-back, no idle cycle).
  - On any return to 0: stop_pending<=0, step_mode<=0.
- pc_e defaults to 0 every cycle it is not set as above.
- instr_out is stable for the whole instruction and changes only on entry to phase 1.
- Latency: start pulse -> phase 1 on the next edge. Sustained throughput is one instruction per NUM_PHASES cycles.
- phase_oh and executing are decoded combinationally from the registered phase.

Test Plan:
- Reset: hold rst=0 mid-phase 3 -> outputs immediately 0. Release; no button -> phase stays 0 for 20 cycles.
- Run: exec held high 10 cycles, instr_in=16'hA5A5 then 16'h1234 -> one start. Phase sequence 1,2,3,4,5,1,2… instr_out=A5A5 in the first instruction and 1234 in the second. pc_e high exactly in cycles after each phase 5. instr_count increments 1,2.
- Stop: while running, exec pulse in phase 2 -> current instruction finishes phase 5, then phase=0. instr_count +1 only. A second exec pulse in phase 5 of a later run also stops at that boundary.
- Single-step: step pulse from idle -> exactly 5 phases, one pc_e, phase=0. step pulse during execution has no effect. step+exec in the same cycle -> free run.
- Halt: halt_req=1 asserted only in phase 3 -> ignored. halt_req=1 in phase 5 -> phase=0, halted=1. Next exec pulse clears halted and resumes.
- Wrap/param: NUM_PHASES=3, CNT_W=4, run 17 instructions -> instr_count=1. phase_oh walks 001,010,100.
